// File: rtl/stopwatch_pkg.sv
// Shared definitions for the StopWatch input-conditioning blocks:
// edge-mode encodings, debounce FSM states and the edge qualification rule.
package stopwatch_pkg;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } deb_state_t;

  // The direction of an event is defined by the level the channel settles to.
  function automatic logic edge_qualifies(input logic [1:0] sel, input logic new_level);
    return new_level ? |(sel & EDGE_RISE) : |(sel & EDGE_FALL);
  endfunction

endpackage

// File: rtl/multi_edge_detector_if.sv
// Bundle of per-channel button inputs, edge controls and conditioned outputs.
// The master side drives the raw inputs; the detector is the slave.
interface multi_edge_detector_if #(
  parameter int CH = 4
);
  logic [CH-1:0]   din;
  logic [2*CH-1:0] edge_sel;
  logic [CH-1:0]   clr_toggle;
  logic [CH-1:0]   level_db;
  logic [CH-1:0]   pulse;
  logic [CH-1:0]   toggle;

  modport master (
    output din, edge_sel, clr_toggle,
    input  level_db, pulse, toggle
  );

  modport slave (
    input  din, edge_sel, clr_toggle,
    output level_db, pulse, toggle
  );
endinterface

// File: rtl/edge_chan.sv
// One input channel: synchroniser, debounce FSM with stability counter,
// edge qualification, registered pulse and clearable toggle.
module edge_chan
  import stopwatch_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic INIT_LEVEL      = 1'b0
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic       din,
  input  logic [1:0] edge_sel,
  input  logic       clr_toggle,
  output logic       level_db,
  output logic       pulse,
  output logic       toggle
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  deb_state_t             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   level_reg, level_next;
  logic                   pulse_reg, pulse_next;
  logic                   toggle_reg, toggle_next;
  logic                   sync_s;
  logic                   deb_event;

  assign sync_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge Clk) begin
    if (rst) begin
      sync_reg   <= {SYNC_STAGES{INIT_LEVEL}};
      state_reg  <= ST_STABLE;
      cnt_reg    <= '0;
      level_reg  <= INIT_LEVEL;
      pulse_reg  <= 1'b0;
      toggle_reg <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], din};
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      level_reg  <= level_next;
      pulse_reg  <= pulse_next;
      toggle_reg <= toggle_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level_reg;
    deb_event  = 1'b0;
    case (state_reg)
      ST_STABLE: begin
        if (sync_s != level_reg) begin
          // A one-cycle debounce window accepts the new level immediately.
          if (DEBOUNCE_CYCLES == 1) begin
            level_next = sync_s;
            deb_event  = 1'b1;
          end else begin
            cnt_next   = CNT_W'(1);
            state_next = ST_COUNTING;
          end
        end
      end
      ST_COUNTING: begin
        if (sync_s == level_reg) begin
          cnt_next   = '0;
          state_next = ST_STABLE;
        end else if (cnt_reg == CNT_LAST) begin
          level_next = sync_s;
          cnt_next   = '0;
          state_next = ST_STABLE;
          deb_event  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_STABLE;
      end
    endcase
    pulse_next  = deb_event && edge_qualifies(edge_sel, level_next);
    // Clear beats a simultaneous event; the pulse itself is still reported.
    toggle_next = clr_toggle ? 1'b0 : (toggle_reg ^ pulse_next);
  end

  assign level_db = level_reg;
  assign pulse    = pulse_reg;
  assign toggle   = toggle_reg;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel button conditioner: CH independent edge_chan instances,
// each fed its own two-bit slice of edge_sel.
module multi_edge_detector
  import stopwatch_pkg::*;
#(
  parameter int   CH              = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic INIT_LEVEL      = 1'b0
) (
  input logic                  Clk,
  input logic                  rst,
  multi_edge_detector_if.slave bus
);

  logic [CH-1:0] level_w;
  logic [CH-1:0] pulse_w;
  logic [CH-1:0] toggle_w;

  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT_LEVEL     (INIT_LEVEL)
    ) u_chan (
      .Clk       (Clk),
      .rst       (rst),
      .din       (bus.din[gi]),
      .edge_sel  (bus.edge_sel[2*gi +: 2]),
      .clr_toggle(bus.clr_toggle[gi]),
      .level_db  (level_w[gi]),
      .pulse     (pulse_w[gi]),
      .toggle    (toggle_w[gi])
    );
  end

  assign bus.level_db = level_w;
  assign bus.pulse    = pulse_w;
  assign bus.toggle   = toggle_w;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Randomised scoreboard bench for multi_edge_detector: the driver pushes the
// expected outputs of every clock edge, the monitor pops and compares them.
module tb_multi_edge_detector;

  localparam int   CH   = 4;
  localparam int   SYNC = 2;
  localparam int   DEB  = 4;
  localparam logic INIT = 1'b0;
  localparam int   MAXE = 4096;

  logic Clk = 1'b0;
  logic rst;
  always #5 Clk = ~Clk;

  multi_edge_detector_if #(.CH(CH)) bus ();

  multi_edge_detector #(
    .CH             (CH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .INIT_LEVEL     (INIT)
  ) dut (
    .Clk(Clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [CH-1:0] level;
    logic [CH-1:0] pulse;
    logic [CH-1:0] toggle;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   drv_done = 1'b0;

  // Reference model: raw input history indexed by edge number. The debounced
  // level flips at edge n when the synchronised value at each of the last DEB
  // edges (all after the previous flip or reset) differed from the level.
  bit            din_at[CH][MAXE];
  int            mark[CH];
  int            edge_n   = -1;
  int            rst_edge = -1;
  logic [CH-1:0] m_level, m_pulse, m_toggle;

  function automatic bit s_at(int c, int n);
    if (n - SYNC > rst_edge) return din_at[c][n-SYNC];
    return INIT;
  endfunction

  task automatic model_step(input logic r, input logic [CH-1:0] d,
                            input logic [2*CH-1:0] sel, input logic [CH-1:0] clr);
    exp_t e;
    edge_n++;
    if (r) begin
      rst_edge = edge_n;
      m_level  = {CH{INIT}};
      m_pulse  = '0;
      m_toggle = '0;
      for (int c = 0; c < CH; c++) mark[c] = edge_n;
    end else begin
      for (int c = 0; c < CH; c++) begin
        bit flip;
        bit qual;
        din_at[c][edge_n] = d[c];
        flip = 1'b1;
        for (int k = 0; k < DEB; k++) begin
          int m;
          m = edge_n - k;
          if (m <= mark[c] || s_at(c, m) == m_level[c]) flip = 1'b0;
        end
        if (flip) begin
          m_level[c] = ~m_level[c];
          mark[c]    = edge_n;
        end
        qual        = flip && (m_level[c] ? sel[2*c] : sel[2*c+1]);
        m_pulse[c]  = qual;
        m_toggle[c] = clr[c] ? 1'b0 : (m_toggle[c] ^ qual);
      end
    end
    e.level  = m_level;
    e.pulse  = m_pulse;
    e.toggle = m_toggle;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [CH-1:0] d,
                       input logic [2*CH-1:0] sel, input logic [CH-1:0] clr);
    rst            = r;
    bus.din        = d;
    bus.edge_sel   = sel;
    bus.clr_toggle = clr;
    model_step(r, d, sel, clr);
  endtask

  task automatic cycle(input logic r, input logic [CH-1:0] d,
                       input logic [2*CH-1:0] sel, input logic [CH-1:0] clr);
    @(negedge Clk);
    drive(r, d, sel, clr);
  endtask

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s edge=%0d actual=%b required=%b", name, edge_n, act, req);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #2;
      if (exp_q.size() == 0) begin
        if (!drv_done) begin
          n_checks++;
          n_fail++;
          $display("FAIL no_expectation at time %0t actual=none required=entry", $time);
        end
      end else begin
        e = exp_q.pop_front();
        check("level_db", bus.level_db, e.level);
        check("pulse", bus.pulse, e.pulse);
        check("toggle", bus.toggle, e.toggle);
        if (bus.pulse != '0)
          $display("event t=%0t pulse=%b toggle=%b level_db=%b",
                   $time, bus.pulse, bus.toggle, bus.level_db);
      end
    end
  end

  // Driver
  initial begin
    logic [CH-1:0]   d;
    logic [2*CH-1:0] sel;
    logic [CH-1:0]   clr;
    int              rst_left;

    drive(1'b1, '0, '0, '0);
    cycle(1'b1, '0, '0, '0);
    cycle(1'b1, '0, '0, '0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 8'hFF, '0);

    d        = '0;
    sel      = 8'h55;
    rst_left = 0;
    for (int i = 0; i < 2400; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(6) == 0) d[c] = ~d[c];
      if ($urandom_range(39) == 0) sel = 8'($urandom);
      for (int c = 0; c < CH; c++) clr[c] = ($urandom_range(15) == 0);
      if (rst_left == 0 && $urandom_range(299) == 0) rst_left = int'($urandom_range(3, 1));
      cycle(rst_left != 0, d, sel, clr);
      if (rst_left != 0) rst_left--;
    end

    // All channels see the same clean edges together.
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 8'h55, '0);
    for (int i = 0; i < 12; i++) cycle(1'b0, '1, 8'h55, '0);
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 8'hFF, '0);

    @(posedge Clk);
    #4;
    drv_done = 1'b1;
    repeat (3) @(posedge Clk);
    #4;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised, multi-channel successor to the single-bit rising-edge toggle detector used for StopWatch button handling.
- Per channel, in order:
  - synchronises an asynchronous input through a configurable flop chain;
  - debounces it with a stability counter;
  - detects rising, falling or both edges, selectable at run time;
  - produces a one-cycle pulse and a toggle state with synchronous clear.
- Sits between board buttons/switches and the StopWatch control FSM; one instance serves all keys.

Parameters:
- CH, 4, number of independent channels.
- SYNC_STAGES, 2, synchroniser depth; legal range is 2 or more.
- DEBOUNCE_CYCLES, 500000, number of consecutive cycles the synchronised input must differ from the debounced level before that level flips; legal range is 1 or more.
- INIT_LEVEL, 1'b0, reset value of the synchroniser flops and the debounced level for every channel.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, never overridden.

Ports:
- Clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  CH  raw asynchronous inputs.
- edge_sel  input  2*CH  per-channel edge mode; bits [2i+1:2i] belong to channel i. 00 = none, 01 = rising, 10 = falling, 11 = both.
- clr_toggle  input  CH  synchronous clear of the toggle state, per channel.
- level_db  output  CH  debounced level.
- pulse  output  CH  one-cycle strobe on each qualifying debounced edge.
- toggle  output  CH  inverts on each qualifying debounced edge.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: it takes effect only on a Clk rising edge while rst = 1.
- Reset values:
  - synchroniser flops and level_db = INIT_LEVEL;
  - debounce counters = 0;
  - pulse = 0;
  - toggle = 0.
- Because the synchroniser resets to INIT_LEVEL, no spurious edge is generated after reset.
- Reset mid-debounce discards the partial count. Reset has priority over every other input.
- Synchroniser: din[i] shifts through SYNC_STAGES flops; s[i] is the last stage.
- Debounce, per channel; each channel is a two-state FSM (STABLE, COUNTING):
  - STABLE (cnt = 0). If s != level_db, cnt <= 1 and go to COUNTING. If DEBOUNCE_CYCLES = 1, level_db flips instead and the FSM stays in STABLE.
  - COUNTING, when s == level_db: cnt <= 0, go to STABLE. This is a glitch and produces no event.
  - COUNTING, when s != level_db and cnt == DEBOUNCE_CYCLES-1: level_db <= s, cnt <= 0, go to STABLE. This is the debounced event.
  - COUNTING, otherwise: cnt <= cnt+1.
- Latency: a clean din transition that meets setup before edge E0 changes level_db at edge E0 + SYNC_STAGES + DEBOUNCE_CYCLES - 1. A pulse shorter than DEBOUNCE_CYCLES cycles at s never reaches level_db.
- Event qualification: an event is rising if the new level_db is 1 and falling if it is 0. It qualifies if edge_sel enables that direction in the cycle the event occurs.
- Pulse and toggle timing:
  - pulse[i] is registered and asserted in the cycle after the edge that updates level_db, together with the new level_db; it lasts exactly one cycle.
  - Back-to-back events are impossible when DEBOUNCE_CYCLES is 2 or more. When DEBOUNCE_CYCLES = 1, pulse can assert on consecutive cycles.
  - toggle[i] inverts on the same edge that asserts pulse[i].
- edge_sel changes take effect from the next cycle. level_db never depends on edge_sel; with edge_sel = 00 the channel still debounces but never pulses or toggles.
- clr_toggle[i] = 1 forces toggle[i] to 0 on the next edge. If clr_toggle and a qualifying event fall on the same edge, clear wins (toggle = 0), but pulse is still asserted.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- Counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.

Decomposition:
- Shared package (stopwatch_pkg):
  - edge-mode constants EDGE_NONE = 2'b00, EDGE_RISE = 2'b01, EDGE_FALL = 2'b10, EDGE_BOTH = 2'b11;
  - debounce-state encoding ST_STABLE / ST_COUNTING.
- One natural sub-module, edge_chan: synchroniser, debounce FSM/counter, qualification, pulse and toggle for a single channel, with the same parameters except CH.
- multi_edge_detector is a generate loop of CH edge_chan instances plus edge_sel slicing.

Test Plan:
1. Reset and quiet input. Settings: CH=4, SYNC=2, DEB=4; rst=1 for 3 cycles, then din=0. Required: level_db, pulse and toggle stay 0 for 20 cycles.
2. Clean rising edge. din[0] 0->1 before E0 with edge_sel[1:0]=01. Required: level_db[0]=1 at edge E0+5, pulse[0] high for exactly the one cycle after that edge, toggle[0]=1. Then din[0] 1->0 produces no pulse and level_db[0]=0 five edges later.
3. Glitch rejection. din[1] high for 3 cycles, then low. Required: level_db[1], pulse[1] and toggle[1] unchanged. A following 4-cycle high is accepted.
4. Both-edges mode and toggle. edge_sel[5:4]=11, two clean press/release pairs on din[2]. Required: 4 pulses, and toggle[2] sequence 1, 0, 1, 0.
5. Clear collision. Assert clr_toggle[3] on the same edge as a qualifying rising event on channel 3 (toggle[3]=0 beforehand). Required: pulse[3]=1, toggle[3]=0.
6. Reset mid-operation and multi-channel. Assert rst while channels 0 and 2 are in COUNTING. Required: all counts discarded, outputs return to reset values, no pulse on release of rst. Then simultaneous clean edges on all 4 channels with edge_sel=all 01 give pulse = 4'b1111 in a single cycle.
